tt_gpio_ctrl: RTL and testbench

Parametrised bidirectional-pad controller for the Tiny Tapeout user I/O bank. It replaces the fixed tie-low driving of the bidirectional pads with command-driven registers: output value, output enable, timed pulse generation, and synchronised input readback with sticky rising-edge capture. It sits between the project top level and the uio pads.

---
 rtl/tt_gpio_pkg.sv | 22 ++
 rtl/tt_sync_edge.sv | 35 +++
 rtl/tt_gpio_ctrl.sv | 115 +++++++++++
 tb/tb_tt_gpio_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tt_gpio_pkg.sv
// Shared encodings for the uio pad controller: command opcodes and FSM states.
// No logic; imported by the controller and its synchroniser.
package tt_gpio_pkg;

    typedef enum logic [1:0] {
        OP_WR_OUT = 2'd0,
        OP_WR_OE  = 2'd1,
        OP_PULSE  = 2'd2,
        OP_READ   = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

    // Pulse counter width, never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-stage synchroniser with rising-edge detect; SYNC_STAGES cycles to o_sync,
// o_rise is combinational from the last two stages. No backpressure.
module tt_sync_edge
    import tt_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_pad,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tt_gpio_ctrl.sv
// Command-driven uio pad controller: output/enable regs, timed pulse, synced readback with sticky edges.
// Commands take effect on the accepting edge; cmd_ready is low only while a pulse runs (no queueing).
module tt_gpio_ctrl
    import tt_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             edge_irq
);

    localparam int CW = cnt_width(PULSE_LEN);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_sticky;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic             w_accept;
    op_e              w_op;
    logic [WIDTH-1:0] w_clr;

    tt_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .i_pad  (pad_in),
        .o_sync (w_sync),
        .o_rise (w_rise)
    );

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_op     = op_e'(cmd_op);
    assign w_clr    = {WIDTH{w_accept && (w_op == OP_READ) && cmd_data[0]}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_out      <= '0;
            r_oe       <= '0;
            r_mask     <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (w_op)
                            OP_WR_OUT: r_out <= cmd_data;
                            OP_WR_OE:  r_oe  <= cmd_data;
                            OP_PULSE: begin
                                r_out   <= r_out ^ cmd_data;
                                r_mask  <= cmd_data;
                                r_cnt   <= CW'(PULSE_LEN - 1);
                                r_state <= ST_PULSE;
                            end
                            OP_READ: begin
                                r_rd_data  <= cmd_data[0] ? r_sticky : w_sync;
                                r_rd_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PULSE: begin
                    // Restore uses the stored mask, so later edits cannot skew it.
                    if (r_cnt == '0) begin
                        r_out   <= r_out ^ r_mask;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    // A rise landing in the clear cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~w_clr) | w_rise;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign pad_out   = r_out;
    assign pad_oe    = r_oe;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign edge_irq  = |r_sticky;

endmodule

// File: tb/tb_tt_gpio_ctrl.sv
// Directed bench for tt_gpio_ctrl; read results are checked through an expected-value queue.
module tb_tt_gpio_ctrl;
    import tt_gpio_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] pad_in = 8'h00;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       edge_irq;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    tt_gpio_ctrl #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .PULSE_LEN   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .pad_in    (pad_in),
        .pad_out   (pad_out),
        .pad_oe    (pad_oe),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .edge_irq  (edge_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cmd(input op_e op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    // Monitor: every rd_valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got rd_data 0x%0h with nothing expected", rd_data);
            end else begin
                check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_pad_out",   pad_out,   8'h00);
        check("rst_pad_oe",    pad_oe,    8'h00);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_edge_irq",  edge_irq,  1'b0);
        check("rst_rd_valid",  rd_valid,  1'b0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Back-to-back writes
        cmd(OP_WR_OE, 8'hF0);
        tick();
        check("wr_oe", pad_oe, 8'hF0);
        check("wr_oe_out_untouched", pad_out, 8'h00);
        cmd(OP_WR_OUT, 8'hA5);
        tick();
        check("wr_out", pad_out, 8'hA5);
        check("wr_out_oe_held", pad_oe, 8'hF0);

        // Pulse with an ignored write presented while busy
        cmd(OP_PULSE, 8'h0F);
        tick();
        check("pulse_out_c0", pad_out, 8'hAA);
        check("pulse_ready_c0", cmd_ready, 1'b0);
        cmd(OP_WR_OUT, 8'h00);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("pulse_out", pad_out, 8'hAA);
            check("pulse_ready", cmd_ready, 1'b0);
        end
        tick();
        check("pulse_restore", pad_out, 8'hA5);
        check("pulse_ready_back", cmd_ready, 1'b1);
        idle();
        tick();
        check("pulse_write_not_queued", pad_out, 8'hA5);

        // Edge capture and readback
        pad_in = 8'h81;
        tick();
        check("irq_edge1", edge_irq, 1'b0);
        tick();
        check("irq_edge2", edge_irq, 1'b0);
        tick();
        check("irq_edge3", edge_irq, 1'b1);
        cmd(OP_READ, 8'h00);
        exp_q.push_back(8'h81);
        tick();
        cmd(OP_READ, 8'h01);
        exp_q.push_back(8'h81);
        tick();
        cmd(OP_READ, 8'hFF);
        exp_q.push_back(8'h00);
        tick();
        check("irq_after_clear", edge_irq, 1'b0);
        idle();
        tick();
        check("rd_valid_drop", rd_valid, 1'b0);

        // New rise in the same cycle as a read-clear
        pad_in = 8'h83;
        tick();
        tick();
        tick();
        check("irq_bit1", edge_irq, 1'b1);
        pad_in = 8'h87;
        tick();
        tick();
        cmd(OP_READ, 8'h01);
        exp_q.push_back(8'h02);
        tick();
        check("irq_survives_clear", edge_irq, 1'b1);
        cmd(OP_READ, 8'h01);
        exp_q.push_back(8'h04);
        tick();
        idle();
        check("irq_cleared_bit2", edge_irq, 1'b0);
        tick();

        // Reset in the second cycle of a pulse
        pad_in = 8'h00;
        cmd(OP_PULSE, 8'h0F);
        tick();
        check("rp_out_toggled", pad_out, 8'hAA);
        idle();
        tick();
        rst = 1'b1;
        #1;
        check("rp_out_async", pad_out, 8'h00);
        check("rp_oe_async", pad_oe, 8'h00);
        check("rp_ready_async", cmd_ready, 1'b1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rp_no_restore", pad_out, 8'h00);
            check("rp_ready", cmd_ready, 1'b1);
        end

        check("rd_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
